// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM states and the iteration counter width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int CNT_W     = $clog2(MDU_WIDTH);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement: out_val = neg ? -in_val : in_val.
// Used both for operand magnitudes and for the final sign fix-up.
module mdu_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] in_val,
    output logic [WIDTH-1:0] out_val
);

    assign out_val = neg ? -in_val : in_val;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the HI/LO pair; one shift-add or
// restoring-divide step per cycle on operand magnitudes, then a sign fix-up.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int               WIDTH   = MDU_WIDTH,
    parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 in_signed;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH-1:0]     mul_addend;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_tmp;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign in_signed = op_is_signed(op);

    mdu_negate #(.WIDTH(WIDTH)) u_abs_a (
        .neg     (in_signed & a[WIDTH-1]),
        .in_val  (a),
        .out_val (abs_a)
    );

    mdu_negate #(.WIDTH(WIDTH)) u_abs_b (
        .neg     (in_signed & b[WIDTH-1]),
        .in_val  (b),
        .out_val (abs_b)
    );

    mdu_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
        .neg     (neg_res_q),
        .in_val  (acc_q),
        .out_val (prod_fix)
    );

    mdu_negate #(.WIDTH(WIDTH)) u_fix_quot (
        .neg     (neg_res_q),
        .in_val  (acc_q[WIDTH-1:0]),
        .out_val (quot_fix)
    );

    mdu_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .neg     (neg_rem_q),
        .in_val  (acc_q[2*WIDTH-1:WIDTH]),
        .out_val (rem_fix)
    );

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_addend = acc_q[0] ? opb_q : {WIDTH{1'b0}};
    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits becoming quotient bits}, shifted left each step.
    assign div_tmp  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_tmp - {1'b0, opb_q};
    assign div_next = div_diff[WIDTH] ? {div_tmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // NOTE: every _d gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d     = {{WIDTH{1'b0}}, abs_a};
                    opb_d     = abs_b;
                    a_raw_d   = a;
                    is_div_d  = op_is_div(op);
                    neg_res_d = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = in_signed & a[WIDTH-1];
                    div0_d    = (b == {WIDTH{1'b0}});
                    cnt_d     = '0;
                    state_d   = CALC;
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (div0_q) begin
                    hi_d = a_raw_q;
                    lo_d = DIV0_LO;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignment only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo; observation index k means "sampled on the
// falling edge after rising edge Ek", where E0 is the edge that takes start.
module tb_mdu_hilo;

    localparam int INJ_NONE       = 0;
    localparam int INJ_START      = 1;
    localparam int INJ_MTLO       = 2;
    localparam int INJ_RST        = 3;
    localparam int INJ_MTLO_START = 4;

    logic        clk = 1'b0;
    logic        rst, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    int          r_first_done, r_done_cnt, r_busy_first, r_busy_last, r_busy_cnt;
    logic [31:0] r_hi_pre, r_lo_pre, r_hi, r_lo, r_snap_hi, r_snap_lo;
    logic        r_snap_busy;

    always #5 clk = ~clk;

    mdu_hilo dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Launches one op, then observes a fixed window; operands are scrambled after E0.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int inj_kind, input int inj_cyc, input int window);
        r_first_done = -1; r_done_cnt = 0;
        r_busy_first = -1; r_busy_last = -1; r_busy_cnt = 0;
        r_snap_busy = 1'bx; r_snap_hi = 'x; r_snap_lo = 'x;
        r_hi_pre = 'x; r_lo_pre = 'x;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        if (inj_kind == INJ_MTLO_START) begin
            mtlo = 1'b1; wdata = 32'h5555AAAA;
        end
        for (int k = 0; k <= window; k++) begin
            if (k > 0) @(negedge clk);
            else @(negedge clk);
            if (k == 0) begin
                start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0; mtlo = 1'b0;
            end
            if (busy) begin
                r_busy_cnt++;
                if (r_busy_first < 0) r_busy_first = k;
                r_busy_last = k;
            end
            if (done) begin
                r_done_cnt++;
                if (r_first_done < 0) r_first_done = k;
            end
            if (k == 32) begin
                r_hi_pre = hi; r_lo_pre = lo;
            end
            if (k == inj_cyc + 1) begin
                r_snap_busy = busy; r_snap_hi = hi; r_snap_lo = lo;
                start = 1'b0; mtlo = 1'b0; rst = 1'b0;
            end
            if (k == inj_cyc) begin
                case (inj_kind)
                    INJ_START: begin start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd2; end
                    INJ_MTLO:  begin mtlo = 1'b1; wdata = 32'hA5A5A5A5; end
                    INJ_RST:   rst = 1'b1;
                    default: ;
                endcase
            end
        end
        r_hi = hi; r_lo = lo;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 00000000", lo); end
        rst = 1'b0;
    endtask

    task automatic test_multu_max();
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, INJ_NONE, -10, 40);
        checks++; if (r_busy_first !== 0) begin errors++; $display("FAIL multu_busy_first got %0d exp 0", r_busy_first); end
        checks++; if (r_busy_last !== 32) begin errors++; $display("FAIL multu_busy_last got %0d exp 32", r_busy_last); end
        checks++; if (r_busy_cnt !== 33) begin errors++; $display("FAIL multu_busy_cnt got %0d exp 33", r_busy_cnt); end
        checks++; if (r_first_done !== 33) begin errors++; $display("FAIL multu_done_cycle got %0d exp 33", r_first_done); end
        checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL multu_done_cnt got %0d exp 1", r_done_cnt); end
        checks++; if (r_hi_pre !== 32'h0 || r_lo_pre !== 32'h0) begin
            errors++; $display("FAIL multu_hold got %h_%h exp 00000000_00000000", r_hi_pre, r_lo_pre); end
        checks++; if (r_hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", r_hi); end
        checks++; if (r_lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", r_lo); end
    endtask

    task automatic test_signed();
        run_op(2'b00, 32'hFFFFFFFD, 32'd5, INJ_NONE, -10, 40);
        checks++; if (r_hi_pre !== 32'hFFFFFFFE || r_lo_pre !== 32'h1) begin
            errors++; $display("FAIL mult_hold got %h_%h exp fffffffe_00000001", r_hi_pre, r_lo_pre); end
        checks++; if (r_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", r_hi); end
        checks++; if (r_lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo got %h exp fffffff1", r_lo); end
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, INJ_NONE, -10, 40);
        checks++; if (r_lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_quot got %h exp fffffffd", r_lo); end
        checks++; if (r_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_rem got %h exp ffffffff", r_hi); end
    endtask

    task automatic test_div_edge();
        run_op(2'b11, 32'd100, 32'd0, INJ_NONE, -10, 40);
        checks++; if (r_first_done !== 33) begin errors++; $display("FAIL div0_done_cycle got %0d exp 33", r_first_done); end
        checks++; if (r_lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo got %h exp ffffffff", r_lo); end
        checks++; if (r_hi !== 32'h00000064) begin errors++; $display("FAIL div0_hi got %h exp 00000064", r_hi); end
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, INJ_NONE, -10, 40);
        checks++; if (r_lo !== 32'h80000000) begin errors++; $display("FAIL divovf_lo got %h exp 80000000", r_lo); end
        checks++; if (r_hi !== 32'h0) begin errors++; $display("FAIL divovf_hi got %h exp 00000000", r_hi); end
        run_op(2'b11, 32'd1000, 32'd7, INJ_NONE, -10, 40);
        checks++; if (r_lo !== 32'd142) begin errors++; $display("FAIL divu_quot got %h exp 0000008e", r_lo); end
        checks++; if (r_hi !== 32'd6) begin errors++; $display("FAIL divu_rem got %h exp 00000006", r_hi); end
    endtask

    task automatic test_back_to_back();
        run_op(2'b01, 32'd7, 32'd6, INJ_START, 5, 45);
        checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL b2b_done_cnt got %0d exp 1", r_done_cnt); end
        checks++; if (r_first_done !== 33) begin errors++; $display("FAIL b2b_done_cycle got %0d exp 33", r_first_done); end
        checks++; if (r_busy_last !== 32) begin errors++; $display("FAIL b2b_busy_last got %0d exp 32", r_busy_last); end
        checks++; if (r_hi !== 32'h0) begin errors++; $display("FAIL b2b_hi got %h exp 00000000", r_hi); end
        checks++; if (r_lo !== 32'd42) begin errors++; $display("FAIL b2b_lo got %h exp 0000002a", r_lo); end
    endtask

    task automatic test_reset_mid();
        run_op(2'b11, 32'd1000, 32'd7, INJ_RST, 10, 50);
        checks++; if (r_snap_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", r_snap_busy); end
        checks++; if (r_snap_hi !== 32'h0 || r_snap_lo !== 32'h0) begin
            errors++; $display("FAIL rstmid_hilo got %h_%h exp 00000000_00000000", r_snap_hi, r_snap_lo); end
        checks++; if (r_done_cnt !== 0) begin errors++; $display("FAIL rstmid_done_cnt got %0d exp 0", r_done_cnt); end
        checks++; if (r_busy_cnt !== 11) begin errors++; $display("FAIL rstmid_busy_cnt got %0d exp 11", r_busy_cnt); end
    endtask

    task automatic test_moves();
        @(negedge clk); mthi = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h12345678;
        checks++; if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mthi got %h exp deadbeef", hi); end
        @(negedge clk); mtlo = 1'b0;
        checks++; if (lo !== 32'h12345678) begin errors++; $display("FAIL mtlo got %h exp 12345678", lo); end
        checks++; if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mtlo_keeps_hi got %h exp deadbeef", hi); end
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BADF00D;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
        checks++; if (hi !== 32'h0BADF00D || lo !== 32'h0BADF00D) begin
            errors++; $display("FAIL move_both got %h_%h exp 0badf00d_0badf00d", hi, lo); end
        run_op(2'b01, 32'd2, 32'd3, INJ_MTLO, 10, 40);
        checks++; if (r_snap_lo !== 32'h0BADF00D) begin errors++; $display("FAIL mtlo_busy got %h exp 0badf00d", r_snap_lo); end
        checks++; if (r_lo !== 32'd6) begin errors++; $display("FAIL mtlo_busy_result got %h exp 00000006", r_lo); end
        run_op(2'b01, 32'd4, 32'd5, INJ_MTLO_START, 0, 40);
        checks++; if (r_snap_lo !== 32'd6) begin errors++; $display("FAIL mtlo_start_drop got %h exp 00000006", r_snap_lo); end
        checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL mtlo_start_done got %0d exp 1", r_done_cnt); end
        checks++; if (r_lo !== 32'd20 || r_hi !== 32'h0) begin
            errors++; $display("FAIL mtlo_start_result got %h_%h exp 00000000_00000014", r_hi, r_lo); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_div_edge();
        test_back_to_back();
        test_reset_mid();
        test_moves();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
